// File: rtl/adc_resp_pkg.sv
// Shared constants, state encoding and channel-select helper for the
// 0808/0809-style ADC responder.
package adc_resp_pkg;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CONVERT,
        DONE
    } state_e;

    // Pick one channel's 8-bit value out of the flattened analog bus.
    function automatic logic [DATA_W-1:0] chan_sel(
        input logic [NUM_CH*DATA_W-1:0] ain,
        input logic [ADDR_W-1:0]        ch
    );
        return ain[int'(ch)*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/adc_edge_det.sv
// One-register edge detector: pulses rise_o/fall_o for one clk when sig_i
// differs from its previous sampled value.
module adc_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/adc_responder.sv
// Emulated 8-channel, 8-bit SAR ADC with ALE/START/OE/EOC pins, used as the
// responder for loopback testing of the ADC controller.
module adc_responder
    import adc_resp_pkg::*;
#(
    parameter int BIT_CYCLES = 8,
    parameter int EOC_LAG    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     adc_clk,
    input  logic                     ale,
    input  logic                     start,
    input  logic                     out_en,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [NUM_CH*DATA_W-1:0] ain,
    output logic                     eoc,
    output logic [DATA_W-1:0]        result,
    output logic [DATA_W-1:0]        sar_dbg
);

    localparam int CNT_W = $clog2(BIT_CYCLES + 1);
    localparam int LAG_W = $clog2(EOC_LAG + 1);
    localparam int BIT_W = $clog2(DATA_W);

    logic ale_rise, ale_fall;
    logic start_rise, start_fall;
    logic adc_rise, adc_fall;
    logic unused_edges;

    adc_edge_det u_ale_det (
        .clk    (clk),
        .rst_n  (reset),
        .sig_i  (ale),
        .rise_o (ale_rise),
        .fall_o (ale_fall)
    );

    adc_edge_det u_start_det (
        .clk    (clk),
        .rst_n  (reset),
        .sig_i  (start),
        .rise_o (start_rise),
        .fall_o (start_fall)
    );

    adc_edge_det u_adc_det (
        .clk    (clk),
        .rst_n  (reset),
        .sig_i  (adc_clk),
        .rise_o (adc_rise),
        .fall_o (adc_fall)
    );

    assign unused_edges = ale_fall ^ adc_fall;

    state_e             state_q;
    logic [ADDR_W-1:0]  chan_q;
    logic [DATA_W-1:0]  snap_q;
    logic [DATA_W-1:0]  sar_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  result_q;
    logic [BIT_W-1:0]   bit_idx_q;
    logic [CNT_W-1:0]   edge_cnt_q;
    logic [LAG_W-1:0]   lag_cnt_q;
    logic               lag_active_q;
    logic               eoc_q;

    logic [DATA_W-1:0]  bit_mask_d;
    logic [DATA_W-1:0]  next_mask_d;
    logic [DATA_W-1:0]  sar_decided_d;
    logic               last_edge_d;

    // Trial bit survives only if the trial value does not exceed the input.
    always_comb begin
        bit_mask_d            = '0;
        bit_mask_d[bit_idx_q] = 1'b1;
        next_mask_d           = bit_mask_d >> 1;
        sar_decided_d         = (sar_q <= snap_q) ? sar_q : (sar_q & ~bit_mask_d);
        last_edge_d           = adc_rise && (edge_cnt_q == CNT_W'(BIT_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            chan_q       <= '0;
            snap_q       <= '0;
            sar_q        <= '0;
            data_q       <= '0;
            result_q     <= '0;
            bit_idx_q    <= '0;
            edge_cnt_q   <= '0;
            lag_cnt_q    <= '0;
            lag_active_q <= 1'b0;
            eoc_q        <= 1'b1;
        end else begin
            result_q <= out_en ? data_q : '0;

            if (ale_rise) begin
                chan_q <= addr;
            end

            // EOC lag runs independently of state; DONE below overrides it.
            if (lag_active_q) begin
                if (lag_cnt_q == LAG_W'(EOC_LAG - 1)) begin
                    eoc_q        <= 1'b0;
                    lag_active_q <= 1'b0;
                end else begin
                    lag_cnt_q <= lag_cnt_q + LAG_W'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (start_rise) begin
                        state_q      <= ARMED;
                        lag_active_q <= 1'b1;
                        lag_cnt_q    <= '0;
                    end
                end
                ARMED: begin
                    sar_q <= '0;
                    if (start_fall) begin
                        state_q    <= CONVERT;
                        snap_q     <= chan_sel(ain, chan_q);
                        sar_q      <= {1'b1, {(DATA_W-1){1'b0}}};
                        bit_idx_q  <= BIT_W'(DATA_W - 1);
                        edge_cnt_q <= '0;
                    end
                end
                CONVERT: begin
                    if (start_rise) begin
                        state_q <= ARMED;
                        sar_q   <= '0;
                    end else if (last_edge_d) begin
                        if (bit_idx_q != '0) begin
                            sar_q      <= sar_decided_d | next_mask_d;
                            bit_idx_q  <= bit_idx_q - BIT_W'(1);
                            edge_cnt_q <= '0;
                        end else begin
                            sar_q   <= sar_decided_d;
                            data_q  <= sar_decided_d;
                            state_q <= DONE;
                        end
                    end else if (adc_rise) begin
                        edge_cnt_q <= edge_cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    eoc_q        <= 1'b1;
                    lag_active_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign eoc     = eoc_q;
    assign result  = result_q;
    assign sar_dbg = sar_q;

endmodule

// File: doc/adc_responder.md
Name: adc_responder

Overview:
- Synthesizable emulator of an 8-channel, 8-bit successive-approximation ADC with a 0808/0809-style pin interface: ALE, START, OE, ADC clock, 3-bit address, EOC and 8-bit result.
- It is the responder side of our ADC controller. It is used for FPGA loopback and bench closure of the controller without a physical converter.
- Analog inputs are modelled as eight 8-bit digital channel values.

Parameters:
- BIT_CYCLES, 8: adc_clk rising edges spent per SAR bit decision.
- EOC_LAG, 2: clk cycles from detected START rise to EOC low.

Ports:
- clk  in  1  system clock; every input is synchronous to it.
- reset  in  1  asynchronous, active-low reset.
- adc_clk  in  1  converter clock from the controller, sampled in the clk domain.
- ale  in  1  address latch enable.
- start  in  1  conversion start.
- out_en  in  1  output enable (OE).
- addr  in  3  channel select.
- ain  in  64  channel values; channel n occupies bits [8n+7:8n].
- eoc  out  1  end of conversion; high = idle/done, low = converting.
- result  out  8  converted data; 0 when not enabled.
- sar_dbg  out  8  live SAR register, for debug.

Behaviour:
- Reset values:
  - eoc=1, result=8'h00, sar_dbg=8'h00.
  - Channel latch = 0, data latch = 0, state = IDLE.
  - Reset asserted mid-operation forces these values immediately.
- Edge detection:
  - ale, start and adc_clk each pass through a one-register edge detector.
  - An edge is acted on in the clk cycle after it is sampled.
- ALE:
  - On an ale rise in any state, the channel latch takes addr.
  - A conversion already under way keeps its own snapshot.
- States:
  - IDLE:
    - start rise -> ARMED.
  - ARMED (start high):
    - SAR cleared; EOC_LAG counter runs.
    - start fall -> CONVERT.
    - Entering CONVERT: snapshot = ain[channel latch], sar = 8'h80, bit index = 7, edge count = 0.
  - CONVERT:
    - Count adc_clk rises.
    - On the BIT_CYCLES-th rise: keep the current bit if sar <= snapshot, else clear it.
    - If bit index > 0: set the next lower bit, decrement the index, reset the count.
    - If bit index = 0: data latch <= final sar -> DONE.
    - Total conversion time = 8*BIT_CYCLES adc_clk rises after the start fall.
  - DONE:
    - eoc=1 -> IDLE in the same cycle.
- EOC:
  - Drops exactly EOC_LAG clk cycles after the detected start rise.
  - Stays low until DONE.
  - If DONE is reached before the lag expires, the lag is cancelled and eoc stays high.
- Result output:
  - Registered: result <= out_en ? data latch : 8'h00.
  - One clk of latency on both assertion and release of out_en.
  - During a conversion, out_en returns the previous data latch.
- Boundary cases:
  - start rise during CONVERT: abort; return to ARMED, SAR cleared, data latch unchanged, eoc remains low.
  - start held high indefinitely: stay in ARMED with eoc low after the lag.
  - adc_clk stopped: conversion stalls with no timeout.
  - ain changes during CONVERT: ignored, because the snapshot is used.
  - Simultaneous ale rise and start fall: the snapshot uses the previous latch value, and the new address applies to the next conversion.
- Values 8'h00 and 8'hFF must convert exactly.

Decomposition:
- Package adc_resp_pkg:
  - NUM_CH=8, DATA_W=8, ADDR_W=3.
  - State encoding typedef: IDLE, ARMED, CONVERT, DONE.
- One sub-module, adc_edge_det:
  - Signal register with rise and fall pulse outputs.
  - Instantiated three times: ale, start, adc_clk.

Test Plan:
- Reset:
  - Stimulus: assert reset with ain random and toggling inputs.
  - Required response: eoc=1, result=0, sar_dbg=0 throughout; after release, still idle until a start rise.
- Basic conversion:
  - Stimulus: adc_clk period 54 clk; ain ch0=8'hA5; ale pulse with addr=0; start pulse.
  - Required response:
    - eoc low 2 clk after the start rise.
    - sar_dbg[7]=1 after the first bit decision.
    - eoc high after 64 adc_clk rises past the start fall.
    - out_en pulse gives result=8'hA5 one clk later, and 8'h00 one clk after release.
- Channel select:
  - Stimulus: ch5=8'h3C, all other channels 8'hFF, addr=5.
  - Required response: result=8'h3C; repeating with addr=7 gives 8'hFF.
- Extremes:
  - Stimulus: ch2=8'h00, then ch2=8'hFF.
  - Required response: results 8'h00 and 8'hFF exactly.
- Abort and snapshot:
  - Stimulus:
    - Convert 8'h11 to completion.
    - Start a new conversion on 8'h81 and change ain to 8'h22 right after the start fall.
    - Re-pulse start after 20 adc_clk rises.
  - Required response:
    - eoc never rises during the aborted conversion.
    - out_en returns 8'h11 during conversion.
    - The final result is the value of ain at the second start fall.
    - Completion comes 64 rises after that fall.
